// File: rtl/cvxif_copro_responder.sv
// CV-X-IF coprocessor responder: decodes custom-0 offloads, runs single/multi-cycle
// ops and returns results in accept order through a registered result FIFO.
module cvxif_copro_responder #(
  parameter int XLEN          = 64,
  parameter int TRANS_ID_BITS = 3,
  parameter int DEPTH         = 4,
  parameter int MULTI_LAT     = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     x_issue_valid_i,
  output logic                     x_issue_ready_o,
  input  logic [31:0]              x_issue_instr_i,
  input  logic [TRANS_ID_BITS-1:0] x_issue_id_i,
  input  logic [XLEN-1:0]          x_issue_rs1_i,
  input  logic [XLEN-1:0]          x_issue_rs2_i,
  output logic                     x_issue_accept_o,
  output logic                     x_issue_writeback_o,
  output logic                     x_result_valid_o,
  input  logic                     x_result_ready_i,
  output logic [TRANS_ID_BITS-1:0] x_result_id_o,
  output logic [XLEN-1:0]          x_result_data_o,
  output logic [4:0]               x_result_rd_o,
  output logic                     x_result_we_o,
  output logic                     x_result_exc_o,
  output logic [5:0]               x_result_exccode_o
);
  // state | meaning
  // IDLE  | taking offloads; single-cycle ops push straight into the FIFO
  // BUSY  | multi-cycle subtract in flight, issue stalled until it pushes

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (MULTI_LAT > 1) ? $clog2(MULTI_LAT) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] id;
    logic [XLEN-1:0]          data;
    logic [4:0]               rd;
    logic                     we;
    logic                     exc;
    logic [5:0]               exccode;
  } entry_t;

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic [TRANS_ID_BITS-1:0] m_id;
  logic [4:0]               m_rd;
  logic [XLEN-1:0]          m_rs1;
  logic [XLEN-1:0]          m_rs2;

  entry_t                   mem [DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [PTR_W:0]           count;

  logic       is_cus;
  logic [6:0] funct7;
  logic       op_add, op_sub, op_nop, op_exc;
  logic       fifo_full, fire, push, pop, busy_done;
  entry_t     push_entry;
  logic       unused_rs1_field;

  assign unused_rs1_field = ^x_issue_instr_i[19:15];

  assign is_cus = (x_issue_instr_i[6:0] == 7'b0001011) && (x_issue_instr_i[14:12] == 3'b000);
  assign funct7 = x_issue_instr_i[31:25];
  assign op_add = is_cus && (funct7 == 7'd0);
  assign op_sub = is_cus && (funct7 == 7'd1);
  assign op_nop = is_cus && (funct7 == 7'd2);
  assign op_exc = is_cus && (funct7 == 7'd3);

  assign x_issue_accept_o    = op_add | op_sub | op_nop | op_exc;
  assign x_issue_writeback_o = op_add | op_sub;

  assign fifo_full       = (count == (PTR_W+1)'(DEPTH));
  assign x_issue_ready_o = (state == IDLE) && !fifo_full && !flush_i;
  assign fire            = x_issue_valid_i && x_issue_ready_o;
  assign busy_done       = (state == BUSY) && (cnt == '0);

  // Unrecognised encodings complete the handshake but never reach the FIFO.
  assign push = busy_done || (fire && (op_add || op_nop || op_exc));
  assign pop  = x_result_valid_o && x_result_ready_i;

  always_comb begin
    push_entry = '0;
    if (busy_done) begin
      push_entry.id   = m_id;
      push_entry.rd   = m_rd;
      push_entry.data = m_rs1 - m_rs2;
      push_entry.we   = 1'b1;
    end else begin
      push_entry.id      = x_issue_id_i;
      push_entry.rd      = x_issue_instr_i[11:7];
      push_entry.data    = op_add ? (x_issue_rs1_i + x_issue_rs2_i) : '0;
      push_entry.we      = op_add;
      push_entry.exc     = op_exc;
      push_entry.exccode = op_exc ? {1'b0, x_issue_instr_i[24:20]} : 6'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt   <= '0;
      m_id  <= '0;
      m_rd  <= '0;
      m_rs1 <= '0;
      m_rs2 <= '0;
    end else if (flush_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fire && op_sub) begin
            state <= BUSY;
            cnt   <= CNT_W'(MULTI_LAT - 1);
            m_id  <= x_issue_id_i;
            m_rd  <= x_issue_instr_i[11:7];
            m_rs1 <= x_issue_rs1_i;
            m_rs2 <= x_issue_rs2_i;
          end
        end
        BUSY: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign x_result_valid_o   = (count != '0);
  assign x_result_id_o      = mem[rd_ptr].id;
  assign x_result_data_o    = mem[rd_ptr].data;
  assign x_result_rd_o      = mem[rd_ptr].rd;
  assign x_result_we_o      = mem[rd_ptr].we;
  assign x_result_exc_o     = mem[rd_ptr].exc;
  assign x_result_exccode_o = mem[rd_ptr].exccode;

endmodule

// File: tb/tb_cvxif_copro_responder.sv
// Directed bench for cvxif_copro_responder: inputs change on the falling edge,
// outputs are compared on the falling edge against hand-computed values.
module tb_cvxif_copro_responder;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        x_issue_valid_i;
  logic        x_issue_ready_o;
  logic [31:0] x_issue_instr_i;
  logic [2:0]  x_issue_id_i;
  logic [63:0] x_issue_rs1_i;
  logic [63:0] x_issue_rs2_i;
  logic        x_issue_accept_o;
  logic        x_issue_writeback_o;
  logic        x_result_valid_o;
  logic        x_result_ready_i;
  logic [2:0]  x_result_id_o;
  logic [63:0] x_result_data_o;
  logic [4:0]  x_result_rd_o;
  logic        x_result_we_o;
  logic        x_result_exc_o;
  logic [5:0]  x_result_exccode_o;

  int checks = 0;
  int errors = 0;
  int seen;

  cvxif_copro_responder dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .flush_i            (flush_i),
    .x_issue_valid_i    (x_issue_valid_i),
    .x_issue_ready_o    (x_issue_ready_o),
    .x_issue_instr_i    (x_issue_instr_i),
    .x_issue_id_i       (x_issue_id_i),
    .x_issue_rs1_i      (x_issue_rs1_i),
    .x_issue_rs2_i      (x_issue_rs2_i),
    .x_issue_accept_o   (x_issue_accept_o),
    .x_issue_writeback_o(x_issue_writeback_o),
    .x_result_valid_o   (x_result_valid_o),
    .x_result_ready_i   (x_result_ready_i),
    .x_result_id_o      (x_result_id_o),
    .x_result_data_o    (x_result_data_o),
    .x_result_rd_o      (x_result_rd_o),
    .x_result_we_o      (x_result_we_o),
    .x_result_exc_o     (x_result_exc_o),
    .x_result_exccode_o (x_result_exccode_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] rs2f, input logic [4:0] rd);
    return {f7, rs2f, 5'd0, 3'b000, rd, 7'b0001011};
  endfunction

  // Drive one issue request at the falling edge; the handshake lands on the next rising edge.
  task automatic drive(input logic [6:0] f7, input logic [4:0] rs2f, input logic [4:0] rd,
                       input logic [2:0] id, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk_i);
    x_issue_valid_i = 1'b1;
    x_issue_instr_i = mk(f7, rs2f, rd);
    x_issue_id_i    = id;
    x_issue_rs1_i   = a;
    x_issue_rs2_i   = b;
    #1;
  endtask

  task automatic idle_issue();
    @(negedge clk_i);
    x_issue_valid_i = 1'b0;
    #1;
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; x_issue_valid_i = 1'b0; x_issue_instr_i = '0;
    x_issue_id_i = '0; x_issue_rs1_i = '0; x_issue_rs2_i = '0; x_result_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_valid", 64'(x_result_valid_o), 64'd0);
    check("rst_data", x_result_data_o, 64'd0);
    check("rst_id", 64'(x_result_id_o), 64'd0);
    rst_ni = 1'b1;
    #1 check("rst_ready", 64'(x_issue_ready_o), 64'd1);

    // single-cycle add
    x_result_ready_i = 1'b1;
    drive(7'd0, 5'd0, 5'd3, 3'd2, 64'd5, 64'd7);
    check("add_accept", 64'(x_issue_accept_o), 64'd1);
    check("add_wb", 64'(x_issue_writeback_o), 64'd1);
    check("add_ready", 64'(x_issue_ready_o), 64'd1);
    idle_issue();
    check("add_valid", 64'(x_result_valid_o), 64'd1);
    check("add_id", 64'(x_result_id_o), 64'd2);
    check("add_data", x_result_data_o, 64'd12);
    check("add_rd", 64'(x_result_rd_o), 64'd3);
    check("add_we", 64'(x_result_we_o), 64'd1);
    check("add_exc", 64'(x_result_exc_o), 64'd0);
    idle_issue();
    check("add_popped", 64'(x_result_valid_o), 64'd0);

    // multi-cycle subtract: BUSY for 4 cycles, result in N+5
    drive(7'd1, 5'd0, 5'd4, 3'd1, 64'd3, 64'd5);
    check("sub_accept", 64'(x_issue_accept_o), 64'd1);
    check("sub_wb", 64'(x_issue_writeback_o), 64'd1);
    for (int k = 1; k <= 4; k++) begin
      idle_issue();
      check($sformatf("sub_busy_ready_%0d", k), 64'(x_issue_ready_o), 64'd0);
      check($sformatf("sub_busy_valid_%0d", k), 64'(x_result_valid_o), 64'd0);
    end
    idle_issue();
    check("sub_ready_back", 64'(x_issue_ready_o), 64'd1);
    check("sub_valid", 64'(x_result_valid_o), 64'd1);
    check("sub_data", x_result_data_o, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sub_id", 64'(x_result_id_o), 64'd1);
    check("sub_rd", 64'(x_result_rd_o), 64'd4);
    check("sub_we", 64'(x_result_we_o), 64'd1);

    // fill to full, then drain in order
    @(negedge clk_i);
    x_result_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(7'd0, 5'd0, 5'(i + 1), 3'(i), 64'(i * 10), 64'd1);
      check($sformatf("fill_ready_%0d", i), 64'(x_issue_ready_o), 64'd1);
    end
    idle_issue();
    check("full_ready", 64'(x_issue_ready_o), 64'd0);
    check("full_head", 64'(x_result_id_o), 64'd0);
    x_result_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) check("ready_after_pop", 64'(x_issue_ready_o), 64'd1);
      check($sformatf("drain_valid_%0d", i), 64'(x_result_valid_o), 64'd1);
      check($sformatf("drain_id_%0d", i), 64'(x_result_id_o), 64'(i));
      check($sformatf("drain_data_%0d", i), x_result_data_o, 64'(i * 10 + 1));
      check($sformatf("drain_rd_%0d", i), 64'(x_result_rd_o), 64'(i + 1));
      idle_issue();
    end
    check("drained", 64'(x_result_valid_o), 64'd0);

    // unrecognised encoding: handshake completes, nothing queued
    drive(7'h7F, 5'd0, 5'd9, 3'd6, 64'd1, 64'd1);
    check("bad_accept", 64'(x_issue_accept_o), 64'd0);
    check("bad_wb", 64'(x_issue_writeback_o), 64'd0);
    check("bad_ready", 64'(x_issue_ready_o), 64'd1);
    idle_issue();
    check("bad_noresult_1", 64'(x_result_valid_o), 64'd0);
    idle_issue();
    check("bad_noresult_2", 64'(x_result_valid_o), 64'd0);

    // exception op
    x_result_ready_i = 1'b0;
    drive(7'd3, 5'd2, 5'd7, 3'd5, 64'd9, 64'd9);
    check("exc_accept", 64'(x_issue_accept_o), 64'd1);
    check("exc_wb", 64'(x_issue_writeback_o), 64'd0);
    idle_issue();
    check("exc_valid", 64'(x_result_valid_o), 64'd1);
    check("exc_flag", 64'(x_result_exc_o), 64'd1);
    check("exc_code", 64'(x_result_exccode_o), 64'd2);
    check("exc_we", 64'(x_result_we_o), 64'd0);
    check("exc_data", x_result_data_o, 64'd0);
    check("exc_id", 64'(x_result_id_o), 64'd5);
    x_result_ready_i = 1'b1;
    idle_issue();
    check("exc_popped", 64'(x_result_valid_o), 64'd0);

    // flush mid-BUSY with two queued results
    x_result_ready_i = 1'b0;
    drive(7'd0, 5'd0, 5'd1, 3'd1, 64'd100, 64'd1);
    drive(7'd0, 5'd0, 5'd2, 3'd2, 64'd200, 64'd2);
    drive(7'd1, 5'd0, 5'd3, 3'd3, 64'd50, 64'd8);
    check("fl_sub_ready", 64'(x_issue_ready_o), 64'd1);
    idle_issue();
    check("fl_busy_ready", 64'(x_issue_ready_o), 64'd0);
    check("fl_queued", 64'(x_result_valid_o), 64'd1);
    @(negedge clk_i);
    flush_i = 1'b1;
    x_result_ready_i = 1'b1;
    #1 check("fl_ready_in_flush", 64'(x_issue_ready_o), 64'd0);
    idle_issue();
    flush_i = 1'b0;
    #1;
    check("fl_valid", 64'(x_result_valid_o), 64'd0);
    check("fl_ready", 64'(x_issue_ready_o), 64'd1);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      idle_issue();
      if (x_result_valid_o) seen++;
    end
    check("fl_no_ghost", 64'(seen), 64'd0);

    // push and pop on the same edge at count = DEPTH-1
    x_result_ready_i = 1'b0;
    for (int i = 4; i < 7; i++) drive(7'd0, 5'd0, 5'(i), 3'(i), 64'(i), 64'd0);
    drive(7'd0, 5'd0, 5'd7, 3'd7, 64'd7, 64'd0);
    x_result_ready_i = 1'b1;
    #1 check("pp_ready", 64'(x_issue_ready_o), 64'd1);
    check("pp_head", 64'(x_result_id_o), 64'd4);
    idle_issue();
    x_result_ready_i = 1'b0;
    #1;
    check("pp_ready_after", 64'(x_issue_ready_o), 64'd1);
    check("pp_head_after", 64'(x_result_id_o), 64'd5);
    x_result_ready_i = 1'b1;
    for (int i = 5; i < 8; i++) begin
      check($sformatf("pp_id_%0d", i), 64'(x_result_id_o), 64'(i));
      check($sformatf("pp_data_%0d", i), x_result_data_o, 64'(i));
      idle_issue();
    end
    check("pp_empty", 64'(x_result_valid_o), 64'd0);

    // asynchronous reset while BUSY with a queued result
    x_result_ready_i = 1'b0;
    drive(7'd0, 5'd0, 5'd1, 3'd1, 64'd1, 64'd1);
    drive(7'd1, 5'd0, 5'd2, 3'd2, 64'd1, 64'd1);
    idle_issue();
    check("ar_pre_valid", 64'(x_result_valid_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("ar_valid", 64'(x_result_valid_o), 64'd0);
    check("ar_data", x_result_data_o, 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1 check("ar_ready", 64'(x_issue_ready_o), 64'd1);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      idle_issue();
      if (x_result_valid_o) seen++;
    end
    check("ar_no_ghost", 64'(seen), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
